// File: rtl/ps2_keyboard_receiver_pkg.sv
// Shared constants for the PS/2 keyboard receiver: PicoBlaze port IDs,
// status bit positions and the frame FSM state encoding.
package ps2_keyboard_receiver_pkg;

  localparam logic [7:0] PORT_KBD_DATA   = 8'h05;
  localparam logic [7:0] PORT_KBD_STATUS = 8'h06;
  localparam logic [7:0] PORT_KBD_COUNT  = 8'h07;

  localparam int STATUS_NOT_EMPTY = 0;
  localparam int STATUS_OVERFLOW  = 1;
  localparam int STATUS_FRAME_ERR = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // PS/2 uses odd parity: data byte plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
    return ^{data_byte, parity_bit};
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_sync_filter.sv
// Synchronises the raw PS/2 pad signals, debounces the PS/2 clock and emits a
// one-cycle fall_tick on each filtered falling edge.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall_tick
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [1:0]     clk_sync_q, clk_sync_d;
  logic [1:0]     data_sync_q, data_sync_d;
  logic           filt_q, filt_d;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic           fall_tick_q, fall_tick_d;

  // The counter tracks how long the synchronised clock has disagreed with the filtered value.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_d      = filt_q;
    cnt_d       = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + FCW'(1);
      end
    end
    fall_tick_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      fall_tick_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      fall_tick_q <= fall_tick_d;
    end
  end

  assign data_sync = data_sync_q[1];
  assign fall_tick = fall_tick_q;

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard front end: frame FSM with timeout, scan-code FIFO and the
// head/status/count registers read by the PicoBlaze.
module ps2_keyboard_receiver
  import ps2_keyboard_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] scan_code,
  output logic [7:0] status,
  output logic [7:0] fifo_count,
  output logic       rx_busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic data_sync, fall_tick;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .fall_tick (fall_tick)
  );

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          push_req, err_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic          not_empty, full, pop_req, clear_req, do_push;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    push_req  = 1'b0;
    err_set   = 1'b0;
    if (fall_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_sync) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_sync;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_sync && odd_parity_ok(shift_q, parity_q)) push_req = 1'b1;
          else err_set = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      err_set = 1'b1;
    end
    timer_d = (state_d == ST_IDLE || fall_tick) ? '0 : timer_q + TW'(1);
  end

  // When full, a simultaneous pop frees the head slot, so the push may proceed.
  always_comb begin
    not_empty   = (count_q != '0);
    full        = (count_q == CW'(FIFO_DEPTH));
    pop_req     = read_strobe && (port_id == PORT_KBD_DATA) && not_empty;
    clear_req   = read_strobe && (port_id == PORT_KBD_STATUS);
    do_push     = push_req && (!full || pop_req);
    wr_ptr_d    = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_req ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(do_push) - CW'(pop_req);
    overflow_d  = (push_req && full && !pop_req) || (overflow_q && !clear_req);
    frame_err_d = err_set || (frame_err_q && !clear_req);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      timer_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      timer_q     <= timer_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    status                   = 8'h00;
    status[STATUS_NOT_EMPTY] = not_empty;
    status[STATUS_OVERFLOW]  = overflow_q;
    status[STATUS_FRAME_ERR] = frame_err_q;
  end

  assign scan_code  = not_empty ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = {{(8 - CW){1'b0}}, count_q};
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver: frames, pops, flag clearing,
// overflow, timeout, glitch rejection and asynchronous reset.
module tb_ps2_keyboard_receiver;

  localparam int FIFO_DEPTH     = 4;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int HALF           = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] scan_code;
  logic [7:0] status;
  logic [7:0] fifo_count;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_keyboard_receiver #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .port_id     (port_id),
    .read_strobe (read_strobe),
    .scan_code   (scan_code),
    .status      (status),
    .fifo_count  (fifo_count),
    .rx_busy     (rx_busy)
  );

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame layout, LSB sent first: start, 8 data bits, parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_parity);
    return {1'b1, (~^b) ^ bad_parity, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    wait_cycles(HALF);
    ps2_data = 1'b1;
  endtask

  task automatic read_port(input logic [7:0] id);
    port_id     = id;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  initial begin
    reset       = 1'b1;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    port_id     = 8'h00;
    read_strobe = 1'b0;
    wait_cycles(3);
    check_output("reset_scan_code", scan_code, 8'h00);
    check_output("reset_status", status, 8'h00);
    check_output("reset_count", fifo_count, 8'h00);
    check_output("reset_busy", {7'b0, rx_busy}, 8'h00);
    reset = 1'b0;
    wait_cycles(3);

    $display("[TB] valid frame 0x1C");
    send_bits(make_frame(8'h1C, 1'b0), 11);
    check_output("t1_scan_code", scan_code, 8'h1C);
    check_output("t1_status", status, 8'h01);
    check_output("t1_count", fifo_count, 8'h01);
    check_output("t1_busy", {7'b0, rx_busy}, 8'h00);

    $display("[TB] pop and pop-on-empty");
    read_port(8'h05);
    check_output("t2_status", status, 8'h00);
    check_output("t2_count", fifo_count, 8'h00);
    check_output("t2_scan_code", scan_code, 8'h00);
    read_port(8'h05);
    check_output("t2_count_empty_pop", fifo_count, 8'h00);

    $display("[TB] bad parity and flag clear");
    send_bits(make_frame(8'h1C, 1'b1), 11);
    check_output("t3_count", fifo_count, 8'h00);
    check_output("t3_status", status, 8'h04);
    read_port(8'h06);
    check_output("t3_status_cleared", status, 8'h00);

    $display("[TB] overflow with five frames");
    for (int k = 0; k < 5; k++) send_bits(make_frame(8'h11 + 8'(k), 1'b0), 11);
    check_output("t4_count", fifo_count, 8'h04);
    check_output("t4_status", status, 8'h03);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("t4_pop%0d", k), scan_code, 8'h11 + 8'(k));
      read_port(8'h05);
    end
    check_output("t4_count_drained", fifo_count, 8'h00);
    check_output("t4_status_drained", status, 8'h02);
    read_port(8'h06);
    check_output("t4_status_cleared", status, 8'h00);

    $display("[TB] timeout on partial frame");
    send_bits(make_frame(8'hF0, 1'b0), 4);
    check_output("t5_busy_partial", {7'b0, rx_busy}, 8'h01);
    wait_cycles(TIMEOUT_CYCLES + FILTER_LEN + 10);
    check_output("t5_busy_timeout", {7'b0, rx_busy}, 8'h00);
    check_output("t5_status_timeout", status, 8'h04);
    read_port(8'h06);
    send_bits(make_frame(8'hF0, 1'b0), 11);
    check_output("t5_scan_code", scan_code, 8'hF0);
    check_output("t5_status", status, 8'h01);
    read_port(8'h05);
    check_output("t5_count", fifo_count, 8'h00);

    $display("[TB] glitch rejection");
    for (int k = 0; k < 4; k++) begin
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cycles(3);
      ps2_clk  = 1'b1;
      wait_cycles(5);
    end
    ps2_data = 1'b1;
    wait_cycles(HALF);
    check_output("t6_glitch_busy", {7'b0, rx_busy}, 8'h00);
    check_output("t6_glitch_status", status, 8'h00);
    check_output("t6_glitch_count", fifo_count, 8'h00);

    $display("[TB] reset mid-frame");
    send_bits(make_frame(8'h5A, 1'b0), 11);
    check_output("t6_pre_count", fifo_count, 8'h01);
    send_bits(make_frame(8'h33, 1'b0), 3);
    check_output("t6_pre_busy", {7'b0, rx_busy}, 8'h01);
    reset = 1'b1;
    #1;
    check_output("t6_rst_scan_code", scan_code, 8'h00);
    check_output("t6_rst_status", status, 8'h00);
    check_output("t6_rst_count", fifo_count, 8'h00);
    check_output("t6_rst_busy", {7'b0, rx_busy}, 8'h00);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
